ms_mul_operand_sequencer: RTL
=============================

Name: ms_mul_operand_sequencer

Overview:
- Upstream feeder and controller for the serial MS-first multiplier (ms_serial_by4_mul).
- Collects NUM_INPUTS operands from a single valid/ready input stream and drives the multiplier's bin_data_in array and en.
- Watches the multiplier's done, captures its result and presents it on a valid/ready output stream.
- Adds a cycle-count watchdog so that a missing done cannot hang the pipeline.

Parameters:
DATA_WIDTH, 5, operand width in bits
NUM_INPUTS, 2, operands per multiply (>=2)
OUT_WIDTH, DATA_WIDTH*NUM_INPUTS, result width
TIMEOUT, 64, max cycles in RUN awaiting done (>=2)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  sequencer accepts operand
in_data  in  DATA_WIDTH  operand value
mul_en  out  1  to multiplier en
mul_operands  out  DATA_WIDTH x NUM_INPUTS (unpacked array)  to multiplier bin_data_in
mul_done  in  1  from multiplier done
mul_result  in  OUT_WIDTH  from multiplier bin_data_out
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  OUT_WIDTH  captured product
res_err  out  1  qualifies res_data: 1 means timeout, res_data=0
busy  out  1  high in any state except LOAD with zero operands held

Behaviour:
- Reset (rst=0 at a rising edge): state=LOAD, idx=0, mul_en=0, all mul_operands=0, res_valid=0, res_data=0, res_err=0, timer=0, busy=0.
  - Applies from any state, including mid-RUN: mul_en drops on that same edge and any in-flight result is discarded.
- States: LOAD -> RUN -> OUT -> LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: mul_operands[idx]<=in_data, then idx increments. Index 0 is loaded first.
  - When the beat with idx=NUM_INPUTS-1 is accepted at edge T: idx<=0, state<=RUN, mul_en=1 from T, timer<=0.
- RUN:
  - in_ready=0; mul_operands are held stable; mul_en=1.
  - Timer increments every cycle.
  - mul_done=1 sampled at edge D: res_data<=mul_result, res_err<=0, mul_en<=0, res_valid<=1, state<=OUT. Latency from done to res_valid is 1 cycle.
  - If timer reaches TIMEOUT-1 with mul_done=0: res_data<=0, res_err<=1, mul_en<=0, res_valid<=1, state<=OUT.
  - If mul_done and timeout coincide on the same edge, done wins.
- OUT:
  - mul_en=0, in_ready=0.
  - res_valid, res_data and res_err are held stable until res_valid&res_ready. On that edge: res_valid<=0, state<=LOAD.
  - This guarantees mul_en stays low for at least 1 cycle between operations.
- mul_done outside RUN is ignored. in_valid outside LOAD is ignored (not consumed).
- mul_operands keep their last values after the operation; they are overwritten only by new accepts.
- Throughput bound: NUM_INPUTS load cycles + multiply time + 1 + consumer wait.

Test Plan:
- DATA_WIDTH=5, NUM_INPUTS=2; stream 3 then 7 back-to-back -> mul_operands={3,7} (index0=3); mul_en rises the cycle after the second accept. Model asserts done 4 cycles later with result 10'd21 -> res_valid next cycle, res_data=21, res_err=0.
- Same operands with res_ready held 0 for 5 cycles after res_valid -> res_valid/res_data stable for 5 cycles; in_ready=0 throughout; LOAD is re-entered one cycle after the handshake; mul_en=0 during OUT.
- Gapped input (in_valid toggling 1,0,0,1; operands 31, 31) -> exactly two accepts; res_data=961 after done.
- Model never asserts done, TIMEOUT=8 -> mul_en high for 8 cycles; then res_valid=1, res_err=1, res_data=0.
- Drive rst=0 for one cycle 2 cycles into RUN -> next cycle mul_en=0, res_valid=0, state LOAD, idx=0. A subsequent operand pair 2,5 yields 10.
- mul_done pulsed during LOAD and OUT, and in_valid held high during RUN -> no state change, no extra accepts, no extra res_valid.

Source files
------------

// File: rtl/ms_mul_operand_sequencer.sv
// ms_mul_operand_sequencer
// Front-end controller for the serial MS-first multiplier. It gathers
// NUM_INPUTS operands from one valid/ready stream and presents them on the
// multiplier operand bus. While the multiplier is running, mul_en is held
// high. When the multiplier reports done, the product is captured and offered
// on a valid/ready result stream. A cycle watchdog ends a run that never sees
// done. In that case it returns a zero result flagged by res_err_o.

module ms_mul_operand_sequencer #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int OUT_WIDTH  = DATA_WIDTH * NUM_INPUTS,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  mul_en_o,
  output logic [DATA_WIDTH-1:0] mul_operands_o [NUM_INPUTS],
  input  logic                  mul_done_i,
  input  logic [OUT_WIDTH-1:0]  mul_result_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [OUT_WIDTH-1:0]  res_data_o,
  output logic                  res_err_o,
  output logic                  busy_o
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_INPUTS - 1);
  localparam logic [TMR_W-1:0] TIMER_END = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [DATA_WIDTH-1:0]   operands_q [NUM_INPUTS];
  logic [DATA_WIDTH-1:0]   operands_d [NUM_INPUTS];
  logic                    res_valid_q, res_valid_d;
  logic [OUT_WIDTH-1:0]    res_data_q, res_data_d;
  logic                    res_err_q, res_err_d;

  logic                    in_ready;
  logic                    mul_en;

  // State, index, watchdog, operand and result registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      timer_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        operands_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        operands_q[i] <= operands_d[i];
      end
    end
  end

  // Next-state logic: load operands, run the multiplier until done or timeout, hold result until taken
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      operands_d[i] = operands_q[i];
    end
    in_ready = 1'b0;
    mul_en   = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid_i) begin
          operands_d[idx_q] = in_data_i;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            timer_d = '0;
            state_d = ST_RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_RUN: begin
        mul_en = 1'b1;
        if (mul_done_i) begin
          res_data_d  = mul_result_i;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else if (timer_q == TIMER_END) begin
          res_data_d  = '0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_OUT: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = ST_LOAD;
        end
      end

      default: begin
        state_d = ST_LOAD;
        idx_d   = '0;
      end
    endcase
  end

  assign in_ready_o     = in_ready;
  assign mul_en_o       = mul_en;
  assign mul_operands_o = operands_q;
  assign res_valid_o    = res_valid_q;
  assign res_data_o     = res_data_q;
  assign res_err_o      = res_err_q;
  assign busy_o         = !((state_q == ST_LOAD) && (idx_q == '0));

endmodule
